// File: rtl/square_wave_gen_multi.sv
// square_wave_gen_multi: C-channel programmable square/PWM generator.
// Each channel runs a HIGH/LOW phase FSM with its own active phase lengths.
// Reprogramming is glitch-free: a load strobe fills per-channel pending regs,
// which are copied into the active regs only at that channel's period boundary.
// Ports:
//   clock, reset       system clock, synchronous active-high reset
//   enable[C]          per-channel run enable
//   load               1-cycle strobe capturing hi_count/lo_count for all channels
//   hi_count/lo_count  C*N packed phase lengths, channel i at [i*N +: N]
//   outsignal[C]       registered wave output
//   max_count[C*N]     current phase counter per channel
//   period_done[C]     pulse on the last cycle of each channel's period
//   pending[C]         channel holds captured values not yet applied
// Optional feature macro COMPLEMENT_OUT_EN adds outsignal_n[C]: ~outsignal
// while the channel runs, 0 when idle or in reset.

module swg_chan #(
  parameter int N = 4
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         enable,
  input  logic         load,
  input  logic [N-1:0] hi_in,
  input  logic [N-1:0] lo_in,
  output logic         out,
  output logic [N-1:0] cnt,
  output logic         period_done,
  output logic         pending
`ifdef COMPLEMENT_OUT_EN
  ,
  output logic         out_n
`endif
);
  typedef enum logic [1:0] {S_IDLE, S_HIGH, S_LOW} state_t;

  state_t       state_q, state_d;
  logic [N-1:0] cnt_q, cnt_d;
  logic [N-1:0] act_hi_q, act_hi_d, act_lo_q, act_lo_d;
  logic [N-1:0] pend_hi_q, pend_hi_d, pend_lo_q, pend_lo_d;
  logic         pending_q, pending_d;
  logic         out_q, out_d;
  logic [N-1:0] start_hi, start_lo;
  logic         hi_end, lo_end;

  assign hi_end = (state_q == S_HIGH) && (cnt_q == act_hi_q - N'(1));
  assign lo_end = (state_q == S_LOW)  && (cnt_q == act_lo_q - N'(1));
  // With no LOW phase the period ends with the HIGH phase.
  assign period_done = lo_end || (hi_end && (act_lo_q == '0));

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    act_hi_d  = act_hi_q;
    act_lo_d  = act_lo_q;
    pend_hi_d = pend_hi_q;
    pend_lo_d = pend_lo_q;
    pending_d = pending_q;

    if (load) begin
      pend_hi_d = hi_in;
      pend_lo_d = lo_in;
      pending_d = 1'b1;
    end
    if (period_done) begin
      // A load landing on the boundary is applied directly, never left pending.
      if (load) begin
        act_hi_d = hi_in;
        act_lo_d = lo_in;
      end else if (pending_q) begin
        act_hi_d = pend_hi_q;
        act_lo_d = pend_lo_q;
      end
      pending_d = 1'b0;
    end else if (state_q == S_IDLE && pending_q) begin
      act_hi_d  = pend_hi_q;
      act_lo_d  = pend_lo_q;
      pending_d = load;
    end

    // A new period starts from the freshly applied values; IDLE starts from
    // the values already active.
    start_hi = period_done ? act_hi_d : act_hi_q;
    start_lo = period_done ? act_lo_d : act_lo_q;

    if (!enable) begin
      state_d = S_IDLE;
      cnt_d   = '0;
    end else if (state_q == S_IDLE || period_done) begin
      cnt_d = '0;
      if (start_hi != '0)      state_d = S_HIGH;
      else if (start_lo != '0) state_d = S_LOW;
      else                     state_d = S_IDLE;
    end else if (hi_end) begin
      state_d = S_LOW;
      cnt_d   = '0;
    end else begin
      cnt_d = cnt_q + N'(1);
    end

    out_d = (state_d == S_HIGH);
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      act_hi_q  <= '0;
      act_lo_q  <= '0;
      pend_hi_q <= '0;
      pend_lo_q <= '0;
      pending_q <= 1'b0;
      out_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      act_hi_q  <= act_hi_d;
      act_lo_q  <= act_lo_d;
      pend_hi_q <= pend_hi_d;
      pend_lo_q <= pend_lo_d;
      pending_q <= pending_d;
      out_q     <= out_d;
    end
  end

  assign out     = out_q;
  assign cnt     = cnt_q;
  assign pending = pending_q;

`ifdef COMPLEMENT_OUT_EN
  logic out_n_q, out_n_d;
  assign out_n_d = (state_d == S_LOW);
  always_ff @(posedge clock) begin
    if (reset) out_n_q <= 1'b0;
    else       out_n_q <= out_n_d;
  end
  assign out_n = out_n_q;
`endif
endmodule

module square_wave_gen_multi #(
  parameter int N = 4,
  parameter int C = 2
) (
  input  logic           clock,
  input  logic           reset,
  input  logic [C-1:0]   enable,
  input  logic           load,
  input  logic [C*N-1:0] hi_count,
  input  logic [C*N-1:0] lo_count,
  output logic [C-1:0]   outsignal,
  output logic [C*N-1:0] max_count,
  output logic [C-1:0]   period_done,
  output logic [C-1:0]   pending
`ifdef COMPLEMENT_OUT_EN
  ,
  output logic [C-1:0]   outsignal_n
`endif
);
  for (genvar gi = 0; gi < C; gi++) begin : g_ch
    swg_chan #(.N(N)) u_ch (
      .clock       (clock),
      .reset       (reset),
      .enable      (enable[gi]),
      .load        (load),
      .hi_in       (hi_count[gi*N +: N]),
      .lo_in       (lo_count[gi*N +: N]),
      .out         (outsignal[gi]),
      .cnt         (max_count[gi*N +: N]),
      .period_done (period_done[gi]),
      .pending     (pending[gi])
`ifdef COMPLEMENT_OUT_EN
      ,
      .out_n       (outsignal_n[gi])
`endif
    );
  end
endmodule

// File: tb/tb_square_wave_gen_multi.sv
module tb_square_wave_gen_multi;
  localparam int N = 4;
  localparam int C = 2;

  logic           clock = 1'b0;
  logic           reset;
  logic [C-1:0]   enable;
  logic           load;
  logic [C*N-1:0] hi_count, lo_count;
  logic [C-1:0]   outsignal, period_done, pending;
  logic [C*N-1:0] max_count;
`ifdef COMPLEMENT_OUT_EN
  logic [C-1:0]   outsignal_n;
`endif

  square_wave_gen_multi #(.N(N), .C(C)) dut (
    .clock(clock), .reset(reset), .enable(enable), .load(load),
    .hi_count(hi_count), .lo_count(lo_count), .outsignal(outsignal),
    .max_count(max_count), .period_done(period_done), .pending(pending)
`ifdef COMPLEMENT_OUT_EN
    , .outsignal_n(outsignal_n)
`endif
  );

  always #5 clock = ~clock;

  typedef struct {
    logic         out;
    logic [N-1:0] cnt;
    logic         pd;
    logic         pend;
    logic         run;
  } exp_t;

  exp_t sb[C][$];
  int   errors = 0;
  int   checks = 0;

  // Reference wave: cycle k of a channel running hi/lo from cycle 0 of a period.
  function automatic void push_cycles(int ch, int hi, int lo, int first, int count, logic pend);
    exp_t e;
    int   p;
    for (int k = first; k < first + count; k++) begin
      e.pend = pend;
      if (hi == 0 && lo == 0) begin
        e.out = 1'b0; e.cnt = '0; e.pd = 1'b0; e.run = 1'b0;
      end else begin
        p = k % (hi + lo);
        e.run = 1'b1;
        if (p < hi) begin
          e.out = 1'b1; e.cnt = N'(p); e.pd = (lo == 0) && (p == hi - 1);
        end else begin
          e.out = 1'b0; e.cnt = N'(p - hi); e.pd = (p == hi + lo - 1);
        end
      end
      sb[ch].push_back(e);
    end
  endfunction

  task automatic tick();
    @(negedge clock);
  endtask

  task automatic test_reset();
    reset = 1'b1; enable = '0; load = 1'b0; hi_count = '0; lo_count = '0;
    tick(); tick();
    checks++;
    if (outsignal !== '0 || max_count !== '0 || period_done !== '0 || pending !== '0) begin
      errors++;
      $display("FAIL reset: out=%b cnt=%h pd=%b pend=%b want all 0", outsignal, max_count, period_done, pending);
    end
    reset = 1'b0;
  endtask

  task automatic test_basic();
    exp_t e;
    hi_count = {4'd4, 4'd3}; lo_count = {4'd4, 4'd2}; load = 1'b1;
    tick(); load = 1'b0;
    checks++;
    if (pending !== 2'b11) begin errors++; $display("FAIL load_pending: got %b want 11", pending); end
    tick();
    checks++;
    if (pending !== 2'b00) begin errors++; $display("FAIL idle_apply: got %b want 00", pending); end
    enable = 2'b01;
    push_cycles(0, 3, 2, 0, 11, 1'b0);
    while (sb[0].size() > 0) begin
      tick();
      for (int ch = 0; ch < C; ch++) if (sb[ch].size() > 0) begin
        e = sb[ch].pop_front(); checks++;
        if (outsignal[ch] !== e.out || max_count[ch*N +: N] !== e.cnt || period_done[ch] !== e.pd || pending[ch] !== e.pend) begin
          errors++;
          $display("FAIL basic ch%0d: out=%b cnt=%0d pd=%b pend=%b want %b %0d %b %b", ch, outsignal[ch], max_count[ch*N +: N], period_done[ch], pending[ch], e.out, e.cnt, e.pd, e.pend);
        end
`ifdef COMPLEMENT_OUT_EN
        if (outsignal_n[ch] !== (e.run ? ~e.out : 1'b0)) begin errors++; $display("FAIL basic_n ch%0d: got %b", ch, outsignal_n[ch]); end
`endif
      end
    end
  endtask

  task automatic test_reload();
    exp_t e;
    // Mid-period (cycle 0 observed): old 3/2 period must finish first.
    hi_count = {4'd4, 4'd1}; lo_count = {4'd4, 4'd1}; load = 1'b1;
    push_cycles(0, 3, 2, 1, 4, 1'b1);
    push_cycles(0, 1, 1, 0, 6, 1'b0);
    while (sb[0].size() > 0) begin
      tick(); load = 1'b0;
      for (int ch = 0; ch < C; ch++) if (sb[ch].size() > 0) begin
        e = sb[ch].pop_front(); checks++;
        if (outsignal[ch] !== e.out || max_count[ch*N +: N] !== e.cnt || period_done[ch] !== e.pd || pending[ch] !== e.pend) begin
          errors++;
          $display("FAIL reload ch%0d: out=%b cnt=%0d pd=%b pend=%b want %b %0d %b %b", ch, outsignal[ch], max_count[ch*N +: N], period_done[ch], pending[ch], e.out, e.cnt, e.pd, e.pend);
        end
      end
    end
  endtask

  task automatic test_duty();
    exp_t e;
    // Each load lands on the boundary cycle, so it applies directly.
    for (int ph = 0; ph < 3; ph++) begin
      case (ph)
        0:       begin hi_count = {4'd4, 4'd0}; lo_count = {4'd4, 4'd5}; push_cycles(0, 0, 5, 0, 10, 1'b0); end
        1:       begin hi_count = {4'd4, 4'd5}; lo_count = {4'd4, 4'd0}; push_cycles(0, 5, 0, 0, 10, 1'b0); end
        default: begin hi_count = {4'd4, 4'd0}; lo_count = {4'd4, 4'd0}; push_cycles(0, 0, 0, 0, 3, 1'b0); end
      endcase
      load = 1'b1;
      while (sb[0].size() > 0) begin
        tick(); load = 1'b0;
        for (int ch = 0; ch < C; ch++) if (sb[ch].size() > 0) begin
          e = sb[ch].pop_front(); checks++;
          if (outsignal[ch] !== e.out || max_count[ch*N +: N] !== e.cnt || period_done[ch] !== e.pd || pending[ch] !== e.pend) begin
            errors++;
            $display("FAIL duty%0d ch%0d: out=%b cnt=%0d pd=%b pend=%b want %b %0d %b %b", ph, ch, outsignal[ch], max_count[ch*N +: N], period_done[ch], pending[ch], e.out, e.cnt, e.pd, e.pend);
          end
        end
      end
    end
  endtask

  task automatic test_enable_drop();
    exp_t e;
    hi_count = {4'd4, 4'd3}; lo_count = {4'd4, 4'd2}; load = 1'b1;
    tick(); load = 1'b0;
    tick();
    enable = 2'b11;
    push_cycles(0, 3, 2, 0, 10, 1'b0);
    for (int ph = 0; ph < 3; ph++) begin
      case (ph)
        0:       push_cycles(1, 4, 4, 0, 2, 1'b0);
        1:       push_cycles(1, 0, 0, 0, 2, 1'b0);
        default: push_cycles(1, 4, 4, 0, 6, 1'b0);
      endcase
      while (sb[1].size() > 0) begin
        tick();
        for (int ch = 0; ch < C; ch++) if (sb[ch].size() > 0) begin
          e = sb[ch].pop_front(); checks++;
          if (outsignal[ch] !== e.out || max_count[ch*N +: N] !== e.cnt || period_done[ch] !== e.pd || pending[ch] !== e.pend) begin
            errors++;
            $display("FAIL endrop%0d ch%0d: out=%b cnt=%0d pd=%b pend=%b want %b %0d %b %b", ph, ch, outsignal[ch], max_count[ch*N +: N], period_done[ch], pending[ch], e.out, e.cnt, e.pd, e.pend);
          end
`ifdef COMPLEMENT_OUT_EN
          if (outsignal_n[ch] !== (e.run ? ~e.out : 1'b0)) begin errors++; $display("FAIL endrop_n ch%0d: got %b", ch, outsignal_n[ch]); end
`endif
        end
      end
      enable[1] = (ph == 1);
    end
    enable = 2'b11;
  endtask

  task automatic test_reset_load();
    exp_t e;
    tick(); tick();   // ch0 now mid-HIGH
    hi_count = {4'd7, 4'd7}; lo_count = {4'd7, 4'd7};
    reset = 1'b1; load = 1'b1;
    tick();
    reset = 1'b0; load = 1'b0;
    checks++;
    if (outsignal !== '0 || max_count !== '0 || period_done !== '0 || pending !== '0) begin
      errors++;
      $display("FAIL reset_load: out=%b cnt=%h pd=%b pend=%b want all 0", outsignal, max_count, period_done, pending);
    end
    // Still enabled, but active regs were cleared: channels must stay idle.
    push_cycles(0, 0, 0, 0, 3, 1'b0);
    push_cycles(1, 0, 0, 0, 3, 1'b0);
    while (sb[0].size() > 0) begin
      tick();
      for (int ch = 0; ch < C; ch++) if (sb[ch].size() > 0) begin
        e = sb[ch].pop_front(); checks++;
        if (outsignal[ch] !== e.out || max_count[ch*N +: N] !== e.cnt || period_done[ch] !== e.pd || pending[ch] !== e.pend) begin
          errors++;
          $display("FAIL post_reset ch%0d: out=%b cnt=%0d pd=%b pend=%b want %b %0d %b %b", ch, outsignal[ch], max_count[ch*N +: N], period_done[ch], pending[ch], e.out, e.cnt, e.pd, e.pend);
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_reload();
    test_duty();
    test_enable_drop();
    test_reset_load();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end
endmodule
